noc_packetizer: RTL and testbench

Network-interface injector sitting directly upstream of a node's local input port. Accepts a send request (destination x/y, body length) plus a stream of payload words from a processing element, and emits one wormhole packet: a HEADER flit carrying control_hdr_t, followed by exactly tail_length TAIL flits. Output uses the node port's enable/ack flit handshake, so it connects straight to a node_port.

---
 rtl/noc_pkg.sv | 61 ++++++
 rtl/noc_packetizer.sv | 123 ++++++++++++
 tb/tb_noc_packetizer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
//   Shared types for the NoC: flit format, destination address, the control
//   header carried by HEADER flits, port directions, the packetizer FSM state
//   and the width constants every NoC block is built against.
//   No ports (package).
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int NOC_FLIT_DATA_W = 32;
    localparam int NOC_ADDR_X_W    = 4;
    localparam int NOC_ADDR_Y_W    = 4;
    localparam int NOC_LEN_W       = 8;

    typedef enum logic {
        HEADER = 1'b0,
        TAIL   = 1'b1
    } flit_type_t;

    typedef struct packed {
        flit_type_t                 flit_type;
        logic [NOC_FLIT_DATA_W-1:0] payload;
    } flit_t;

    typedef struct packed {
        logic [NOC_ADDR_X_W-1:0] x;
        logic [NOC_ADDR_Y_W-1:0] y;
    } addr_t;

    typedef struct packed {
        addr_t                dst_addr;
        logic [NOC_LEN_W-1:0] tail_length;
    } control_hdr_t;

    typedef enum logic [1:0] {
        NORTH,
        SOUTH,
        EAST,
        WEST
    } direction_t;

    typedef enum logic [1:0] {
        PKT_IDLE,
        PKT_HEAD,
        PKT_BODY
    } pkt_state_t;

    // Builds a HEADER flit; the control header sits zero-extended in the
    // low bits of the payload.
    function automatic flit_t make_header(input addr_t dst,
                                          input logic [NOC_LEN_W-1:0] len);
        control_hdr_t hdr;
        flit_t        f;
        hdr.dst_addr    = dst;
        hdr.tail_length = len;
        f.flit_type     = HEADER;
        f.payload       = NOC_FLIT_DATA_W'(hdr);
        return f;
    endfunction

endpackage

// File: rtl/noc_packetizer.sv
// -----------------------------------------------------------------------------
// noc_packetizer
//   Network-interface injector feeding a node's local input port. Takes one
//   send request (destination x/y, body length) and the matching stream of
//   payload words, and emits one wormhole packet: a HEADER flit followed by
//   exactly req_len TAIL flits, on the node port's enable/ack handshake.
//
//   Ports
//     clk, rst             clock (rising edge), synchronous active-high reset
//     req_valid/req_ready  send request handshake (accepted only when idle)
//     req_dst_x/req_dst_y  destination address
//     req_len              number of body words (0 = header-only packet)
//     data_valid/ready     payload word handshake
//     data_word            payload word
//     out_flit/out_enable  registered flit toward the node port
//     out_ack              downstream takes the flit at this edge
//     busy                 packet in progress
// -----------------------------------------------------------------------------
module noc_packetizer
    import noc_pkg::*;
#(
    parameter int FLIT_DATA_W = NOC_FLIT_DATA_W,
    parameter int ADDR_X_W    = NOC_ADDR_X_W,
    parameter int ADDR_Y_W    = NOC_ADDR_Y_W,
    parameter int LEN_W       = NOC_LEN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_X_W-1:0]    req_dst_x,
    input  logic [ADDR_Y_W-1:0]    req_dst_y,
    input  logic [LEN_W-1:0]       req_len,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic [FLIT_DATA_W-1:0] data_word,
    output flit_t                  out_flit,
    output logic                   out_enable,
    input  logic                   out_ack,
    output logic                   busy
);

    // The port types come from noc_pkg, so the parameters must agree with it,
    // and the control header has to fit inside one flit payload.
    if (ADDR_X_W + ADDR_Y_W + LEN_W > FLIT_DATA_W) begin : g_hdr_fit_check
        $error("noc_packetizer: control header does not fit in flit payload");
    end
    if (FLIT_DATA_W != NOC_FLIT_DATA_W || ADDR_X_W != NOC_ADDR_X_W ||
        ADDR_Y_W != NOC_ADDR_Y_W || LEN_W != NOC_LEN_W) begin : g_pkg_match_check
        $error("noc_packetizer: parameters disagree with noc_pkg widths");
    end

    pkt_state_t       state;
    logic [LEN_W-1:0] remaining;
    logic             out_xfer;
    addr_t            req_dst;

    assign out_xfer = out_enable && out_ack;
    assign req_dst  = '{x: req_dst_x, y: req_dst_y};

    // NOTE: handshake readies are combinational from registered state so a
    // request/word is taken in the same cycle it is offered; gating with rst
    // keeps them low while reset is being applied.
    assign req_ready  = (state == PKT_IDLE) && !rst;

    // One-deep output pipeline: a new word may be captured whenever the
    // output register is empty or is being emptied this edge. Once the last
    // word is captured (remaining hits 0) no further words are taken.
    assign data_ready = (state == PKT_BODY) && (remaining != '0) &&
                        (!out_enable || out_ack) && !rst;

    assign busy = (state != PKT_IDLE) || out_enable;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PKT_IDLE;
            remaining  <= '0;
            out_flit   <= '0;
            out_enable <= 1'b0;
        end else begin
            case (state)
                PKT_IDLE: begin
                    if (req_valid && req_ready) begin
                        remaining  <= req_len;
                        out_flit   <= make_header(req_dst, req_len);
                        out_enable <= 1'b1;
                        state      <= PKT_HEAD;
                    end
                end

                PKT_HEAD: begin
                    // out_enable is always set here; the header leaves on ack.
                    if (out_ack) begin
                        out_enable <= 1'b0;
                        state      <= (remaining == '0) ? PKT_IDLE : PKT_BODY;
                    end
                end

                PKT_BODY: begin
                    if (data_valid && data_ready) begin
                        // data_ready implies remaining != 0, so no wrap.
                        out_flit   <= '{flit_type: TAIL, payload: data_word};
                        out_enable <= 1'b1;
                        remaining  <= remaining - LEN_W'(1);
                    end else if (out_xfer) begin
                        out_enable <= 1'b0;
                        if (remaining == '0) begin
                            state <= PKT_IDLE;
                        end
                    end
                end

                default: begin
                    state      <= PKT_IDLE;
                    out_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_packetizer.sv
// -----------------------------------------------------------------------------
// tb_noc_packetizer
//   Directed bench for noc_packetizer. Stimulus pushes the expected flits
//   (header payloads hand-computed) into a scoreboard queue; a monitor pops
//   and compares on every out_enable && out_ack transfer. A producer process
//   feeds payload words and an ack process shapes out_ack.
// -----------------------------------------------------------------------------
module tb_noc_packetizer;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_dst_x;
    logic [3:0]  req_dst_y;
    logic [7:0]  req_len;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data_word;
    flit_t       out_flit;
    logic        out_enable;
    logic        out_ack;
    logic        busy;

    noc_packetizer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dst_x  (req_dst_x),
        .req_dst_y  (req_dst_y),
        .req_len    (req_len),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_word  (data_word),
        .out_flit   (out_flit),
        .out_enable (out_enable),
        .out_ack    (out_ack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef enum {ACK_HIGH, ACK_LOW, ACK_TOGGLE} ack_mode_t;

    int          n_tests    = 0;
    int          n_fail     = 0;
    int          xfer_count = 0;
    flit_t       exp_q [$];
    logic [31:0] data_q [$];
    flit_t       mon_exp;
    ack_mode_t   ack_mode   = ACK_HIGH;
    bit          rand_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one comparison per flit transfer.
    always @(negedge clk) begin
        if (!rst && out_enable && out_ack) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL flit_unexpected: got %0h expected none", out_flit);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_flit !== mon_exp) begin
                    n_fail++;
                    $display("FAIL flit_data: got %0h expected %0h", out_flit, mon_exp);
                end
            end
            xfer_count++;
        end
    end

    // Payload producer: presents the head of data_q, pops on handshake.
    initial begin
        bit hs;
        bit gate;
        data_valid = 1'b0;
        data_word  = '0;
        forever begin
            @(negedge clk);
            hs = data_valid && data_ready;
            @(posedge clk);
            #2;
            if (hs && data_q.size() != 0) void'(data_q.pop_front());
            if (rst) data_q.delete();
            gate       = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            data_valid = (data_q.size() != 0) && gate;
            data_word  = (data_q.size() != 0) ? data_q[0] : '0;
        end
    end

    // Downstream ack shaping.
    initial begin
        out_ack = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ack_mode)
                ACK_HIGH: out_ack = 1'b1;
                ACK_LOW:  out_ack = 1'b0;
                default:  out_ack = !out_ack;
            endcase
        end
    end

    // Queues the expected packet and the payload words, then holds the
    // request until accepted. Returns at posedge+1 of the cycle after accept.
    task automatic issue_req(input logic [3:0] x, input logic [3:0] y,
                             input logic [7:0] len, input logic [31:0] hdr_payload,
                             input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3,
                             output int xfer_at_accept);
        logic [31:0] ws [4];
        flit_t       f;
        bit          done = 1'b0;
        ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
        f.flit_type = HEADER;
        f.payload   = hdr_payload;
        exp_q.push_back(f);
        for (int i = 0; i < int'(len); i++) begin
            f.flit_type = TAIL;
            f.payload   = ws[i];
            exp_q.push_back(f);
            data_q.push_back(ws[i]);
        end
        req_valid = 1'b1;
        req_dst_x = x;
        req_dst_y = y;
        req_len   = len;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (req_valid && req_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid      = 1'b0;
        xfer_at_accept = xfer_count;
        check("req_accept", 64'(done), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        check(name, 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    xa;
        int    xa2;
        int    base;
        bit    hit;
        flit_t hexp;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_dst_x = '0;
        req_dst_y = '0;
        req_len   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_enable", 64'(out_enable), 64'd0);
        check("rst_out_flit",   64'(out_flit),   64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_req_ready",  64'(req_ready),  64'd0);
        check("rst_data_ready", 64'(data_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // T1: x=1 y=3 len=3, ack high, words back-to-back
        issue_req(4'd1, 4'd3, 8'd3, 32'h0000_1303,
                  32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'h0, xa);
        @(negedge clk);
        check("t1_hdr_enable", 64'(out_enable), 64'd1);
        check("t1_hdr_type",   64'(out_flit.flit_type), 64'(HEADER));
        check("t1_hdr_no_data_ready", 64'(data_ready), 64'd0);
        @(negedge clk);
        check("t1_bubble_enable",     64'(out_enable), 64'd0);
        check("t1_bubble_data_ready", 64'(data_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_tail_enable", 64'(out_enable), 64'd1);
        end
        @(negedge clk);
        check("t1_done_busy",      64'(busy),      64'd0);
        check("t1_done_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // T2: header-only packet x=2 y=1
        issue_req(4'd2, 4'd1, 8'd0, 32'h0000_2100,
                  32'h0, 32'h0, 32'h0, 32'h0, xa);
        @(negedge clk);
        check("t2_hdr_enable",  64'(out_enable), 64'd1);
        check("t2_data_ready0", 64'(data_ready), 64'd0);
        @(negedge clk);
        check("t2_idle_busy",      64'(busy),       64'd0);
        check("t2_idle_req_ready", 64'(req_ready),  64'd1);
        check("t2_data_ready1",    64'(data_ready), 64'd0);
        @(posedge clk);
        #1;

        // T3: header stalled 5 cycles by out_ack=0
        ack_mode = ACK_LOW;
        issue_req(4'd4, 4'd7, 8'd2, 32'h0000_4702,
                  32'hD000_0000, 32'hD000_0001, 32'h0, 32'h0, xa);
        hexp.flit_type = HEADER;
        hexp.payload   = 32'h0000_4702;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_enable",     64'(out_enable), 64'd1);
            check("t3_hold_flit",       64'(out_flit),   64'(hexp));
            check("t3_hold_data_ready", 64'(data_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        ack_mode = ACK_HIGH;
        wait_idle("t3_done");

        // T4: toggling ack, random data_valid
        base       = xfer_count;
        ack_mode   = ACK_TOGGLE;
        rand_valid = 1'b1;
        issue_req(4'd15, 4'd0, 8'd4, 32'h0000_F004,
                  32'hE000_0010, 32'hE000_0011, 32'hE000_0012, 32'hE000_0013, xa);
        wait_idle("t4_done");
        ack_mode   = ACK_HIGH;
        rand_valid = 1'b0;
        check("t4_flit_count", 64'(xfer_count - base), 64'd5);

        // T5: reset after 2nd of 4 TAIL flits, then a fresh len=1 packet
        base = xfer_count;
        hit  = 1'b0;
        issue_req(4'd3, 4'd2, 8'd4, 32'h0000_3204,
                  32'hF000_0020, 32'hF000_0021, 32'hF000_0022, 32'hF000_0023, xa);
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge clk);
            #1;
            if (xfer_count - base >= 3) hit = 1'b1;
        end
        check("t5_reach_tail2", 64'(hit), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_rst_out_enable", 64'(out_enable), 64'd0);
        check("t5_rst_busy",       64'(busy),       64'd0);
        check("t5_rst_req_ready",  64'(req_ready),  64'd1);
        @(posedge clk);
        #1;
        base = xfer_count;
        issue_req(4'd5, 4'd9, 8'd1, 32'h0000_5901,
                  32'h1234_5678, 32'h0, 32'h0, 32'h0, xa);
        wait_idle("t5_new_pkt_done");
        check("t5_new_pkt_count", 64'(xfer_count - base), 64'd2);

        // T6: back-to-back len=1 requests; second accepted after first TAIL
        base = xfer_count;
        issue_req(4'd6, 4'd6, 8'd1, 32'h0000_6601,
                  32'h6666_0001, 32'h0, 32'h0, 32'h0, xa);
        issue_req(4'd7, 4'd8, 8'd1, 32'h0000_7801,
                  32'h7777_0002, 32'h0, 32'h0, 32'h0, xa2);
        check("t6_second_accept", 64'(xa2 - base), 64'd2);
        wait_idle("t6_done");
        check("t6_flit_count", 64'(xfer_count - base), 64'd4);

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
